// File: rtl/distortion_pkg.sv
// Shared constants, state encoding and saturation limits for the gain-and-clip distortion stage.
package distortion_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 4;
  localparam int PROD_W   = SAMPLE_W + GAIN_W + 1;
  localparam int THR_W    = SAMPLE_W - 1;

  localparam logic signed [PROD_W-1:0] SAT_POS = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] SAT_NEG = PROD_W'(-32767);

  typedef enum logic [2:0] {
    IDLE,
    MUL_L,
    CLIP_L,
    MUL_R,
    CLIP_R,
    DONE
  } state_t;

endpackage

// File: rtl/distortion_core_if.sv
// Sample/control bus between the codec sample path and the distortion stage.
interface distortion_core_if;
  import distortion_pkg::*;

  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] in_left;
  logic signed [SAMPLE_W-1:0] in_right;
  logic        [GAIN_W-1:0]   gain;
  logic        [SAMPLE_W-1:0] threshold;
  logic                       bypass;
  logic signed [SAMPLE_W-1:0] out_left;
  logic signed [SAMPLE_W-1:0] out_right;
  logic                       out_valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    output sample_valid, in_left, in_right, gain, threshold, bypass,
    input  out_left, out_right, out_valid, busy, overrun
  );

  modport slave (
    input  sample_valid, in_left, in_right, gain, threshold, bypass,
    output out_left, out_right, out_valid, busy, overrun
  );

endinterface

// File: rtl/distortion_core_clip_unit.sv
// Combinational clip of a signed product against unsigned level T; hard clip by default,
// soft knee (quarter slope beyond T, saturated to +/-32767) when DISTORTION_SOFT_CLIP_EN is defined.
module clip_unit
  import distortion_pkg::*;
(
  input  logic signed [PROD_W-1:0]   prod,
  input  logic        [THR_W-1:0]    thr,
  output logic signed [SAMPLE_W-1:0] y
);

  logic signed [PROD_W-1:0] t_pos;
  logic signed [PROD_W-1:0] t_neg;

  assign t_pos = $signed({{(PROD_W-THR_W){1'b0}}, thr});
  assign t_neg = -t_pos;

`ifdef DISTORTION_SOFT_CLIP_EN
  logic signed [PROD_W-1:0] knee_hi;
  logic signed [PROD_W-1:0] knee_lo;

  // Excess beyond the threshold is attenuated by 4 with an arithmetic shift (floors negatives).
  assign knee_hi = t_pos + ((prod - t_pos) >>> 2);
  assign knee_lo = t_neg + ((prod + t_pos) >>> 2);

  always_comb begin
    y = prod[SAMPLE_W-1:0];
    if (prod > t_pos) begin
      y = (knee_hi > SAT_POS) ? SAT_POS[SAMPLE_W-1:0] : knee_hi[SAMPLE_W-1:0];
    end else if (prod < t_neg) begin
      y = (knee_lo < SAT_NEG) ? SAT_NEG[SAMPLE_W-1:0] : knee_lo[SAMPLE_W-1:0];
    end
  end
`else
  always_comb begin
    y = prod[SAMPLE_W-1:0];
    if (prod > t_pos) begin
      y = t_pos[SAMPLE_W-1:0];
    end else if (prod < t_neg) begin
      y = t_neg[SAMPLE_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/distortion_core.sv
// Stereo gain-and-clip stage: one shared multiplier and clip unit, left then right, 5-cycle latency.
// Optional soft knee selected by DISTORTION_SOFT_CLIP_EN (see clip_unit).
module distortion_core
  import distortion_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset_n,
  distortion_core_if.slave  bus
);

  state_t                     state;
  logic signed [SAMPLE_W-1:0] cap_left;
  logic signed [SAMPLE_W-1:0] cap_right;
  logic        [GAIN_W-1:0]   cap_gain;
  logic        [THR_W-1:0]    cap_thr;
  logic                       cap_bypass;
  logic signed [PROD_W-1:0]   prod;
  logic signed [SAMPLE_W-1:0] res_left;
  logic signed [SAMPLE_W-1:0] res_right;
  logic signed [SAMPLE_W-1:0] out_left;
  logic signed [SAMPLE_W-1:0] out_right;
  logic                       out_valid;
  logic                       busy;
  logic                       overrun;

  logic signed [SAMPLE_W-1:0] mul_x;
  logic signed [GAIN_W+1:0]   mul_k;
  logic signed [PROD_W-1:0]   mul_p;
  logic signed [SAMPLE_W-1:0] clip_x;
  logic signed [SAMPLE_W-1:0] clip_y;
  logic signed [SAMPLE_W-1:0] clip_res;

  // Threshold MSB is a sign position the clip level never uses.
  logic unused_thr_msb;
  assign unused_thr_msb = bus.threshold[SAMPLE_W-1];

  // Shared datapath: the state selects which captured channel feeds the multiplier and bypass mux.
  assign mul_x  = (state == MUL_R) ? cap_right : cap_left;
  assign mul_k  = $signed({2'b00, cap_gain} + 6'd1);
  assign mul_p  = PROD_W'(mul_x) * PROD_W'(mul_k);
  assign clip_x = (state == CLIP_R) ? cap_right : cap_left;

  clip_unit u_clip (
    .prod (prod),
    .thr  (cap_thr),
    .y    (clip_y)
  );

  assign clip_res = cap_bypass ? clip_x : clip_y;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state      <= IDLE;
      cap_left   <= '0;
      cap_right  <= '0;
      cap_gain   <= '0;
      cap_thr    <= '0;
      cap_bypass <= 1'b0;
      prod       <= '0;
      res_left   <= '0;
      res_right  <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (bus.sample_valid && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.sample_valid) begin
            cap_left   <= bus.in_left;
            cap_right  <= bus.in_right;
            cap_gain   <= bus.gain;
            cap_thr    <= bus.threshold[THR_W-1:0];
            cap_bypass <= bus.bypass;
            busy       <= 1'b1;
            state      <= MUL_L;
          end
        end
        MUL_L: begin
          prod  <= mul_p;
          state <= CLIP_L;
        end
        CLIP_L: begin
          res_left <= clip_res;
          state    <= MUL_R;
        end
        MUL_R: begin
          prod  <= mul_p;
          state <= CLIP_R;
        end
        CLIP_R: begin
          res_right <= clip_res;
          state     <= DONE;
        end
        DONE: begin
          out_left  <= res_left;
          out_right <= res_right;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_left  = out_left;
  assign bus.out_right = out_right;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.overrun   = overrun;

endmodule
